// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: queues completed ops in a small FIFO and retires
// one per cycle into the register-file write port, the status register and a retire counter.
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 5,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [DATA_W-1:0] in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              wb_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [FLAG_W-1:0] status_flags,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       retire_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] CLS_RR  = 3'b001;
    localparam logic [2:0] CLS_IMM = 3'b010;
    localparam logic [2:0] CLS_UN  = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b110;

    logic [5:0]        r_op  [DEPTH];
    logic [DATA_W-1:0] r_res [DEPTH];
    logic [FLAG_W-1:0] r_flg [DEPTH];
    logic [REG_AW-1:0] r_dst [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [FLAG_W-1:0] r_status;
    logic [15:0]       r_retire_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [5:0]        w_head_op;
    logic [DATA_W-1:0] w_head_res;
    logic [FLAG_W-1:0] w_head_flg;
    logic [REG_AW-1:0] w_head_dst;
    logic              w_head_alu;
    logic              w_head_cmp;
    logic              w_head_wr;

    // Ready comes only from the registered count, so wb_stall never reaches in_ready.
    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid & ~w_full;
    assign w_pop    = ~w_empty & ~wb_stall;
    assign in_ready = ~w_full;

    assign w_head_op  = r_op[r_rd_ptr];
    assign w_head_res = r_res[r_rd_ptr];
    assign w_head_flg = r_flg[r_rd_ptr];
    assign w_head_dst = r_dst[r_rd_ptr];

    always_comb begin
        w_head_alu = 1'b0;
        w_head_cmp = 1'b0;
        case (w_head_op[5:3])
            CLS_RR, CLS_IMM: begin
                w_head_alu = 1'b1;
                w_head_cmp = (w_head_op[2:0] == OP_CMP);
            end
            CLS_UN:  w_head_alu = 1'b1;
            default: w_head_alu = 1'b0;
        endcase
        w_head_wr = w_head_alu & ~w_head_cmp;
    end

    // Payload storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op[r_wr_ptr]  <= in_opcode;
            r_res[r_wr_ptr] <= in_result;
            r_flg[r_wr_ptr] <= in_flags;
            r_dst[r_wr_ptr] <= in_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_status     <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_rf_we <= w_pop & w_head_wr;
            if (w_pop) begin
                r_rf_waddr <= w_head_dst;
                r_rf_wdata <= w_head_res;
                if (w_head_alu) begin
                    r_status     <= w_head_flg;
                    r_retire_cnt <= r_retire_cnt + 16'd1;
                end
            end
        end
    end

    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign status_flags = r_status;
    assign retire_cnt   = r_retire_cnt;

    assign fwd_valid = ~w_empty & w_head_wr;
    assign fwd_addr  = w_head_dst;
    assign fwd_data  = w_head_res;

endmodule
